// File: rtl/booth_divider_if.sv
// booth_divider_if: byte-wide begin/lock/end operand and result bus shared with the Booth multiplier.
interface booth_divider_if #(
  parameter int unsigned WIDTH = 8
);
  logic             beginsig;
  logic             locksig;
  logic [WIDTH-1:0] inbus;
  logic [WIDTH-1:0] outbus;
  logic             endsig;
  logic             errsig;

  // Sequencer side: drives operands and the begin/lock qualifiers.
  modport master (
    output beginsig, locksig, inbus,
    input  outbus, endsig, errsig
  );

  // Arithmetic unit side.
  modport slave (
    input  beginsig, locksig, inbus,
    output outbus, endsig, errsig
  );
endinterface

// File: rtl/booth_divider.sv
// booth_divider: sequential unsigned 2W/W non-restoring divider on the begin/lock/end byte bus.
// Optional feature macro BOOTH_DIV_REM_OUT_EN: when defined, the remainder is returned after the
// quotient (OUT_R state); when undefined, the operation ends with the quotient on outbus.
module booth_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  booth_divider_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] LD_AH = 4'd1;
  localparam logic [3:0] LD_AL = 4'd2;
  localparam logic [3:0] LD_B  = 4'd3;
  localparam logic [3:0] CHECK = 4'd4;
  localparam logic [3:0] DIV   = 4'd5;
  localparam logic [3:0] CORR  = 4'd6;
  localparam logic [3:0] OUT_Q = 4'd7;
`ifdef BOOTH_DIV_REM_OUT_EN
  localparam logic [3:0] OUT_R = 4'd8;
`endif
  localparam logic [3:0] DONE  = 4'd9;

  logic [3:0]       state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;        // partial remainder with sign bit
  logic [WIDTH-1:0] q_q, q_d;        // dividend low half, becomes quotient
  logic [WIDTH-1:0] b_q, b_d;        // divisor
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;    // CHECK rejected the operands
  logic [WIDTH-1:0] outbus_q, outbus_d;
  logic             endsig_q, endsig_d;
  logic             errsig_q, errsig_d;

  logic [WIDTH:0]   a_sh_c;
  logic [WIDTH:0]   a_new_c;

  // One non-restoring step: shift {A,Q} left, then subtract or add B by the old sign of A.
  always_comb begin
    a_sh_c  = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    a_new_c = a_q[WIDTH] ? (a_sh_c + {1'b0, b_q}) : (a_sh_c - {1'b0, b_q});
  end

  // Next-state and datapath/output update; beginsig overrides every other transition.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    q_d      = q_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    outbus_d = outbus_q;
    endsig_d = endsig_q;
    errsig_d = errsig_q;

    if (bus.beginsig) begin
      state_d  = LD_AH;
      a_d      = '0;
      q_d      = '0;
      b_d      = '0;
      cnt_d    = '0;
      err_d    = 1'b0;
      outbus_d = '0;
      endsig_d = 1'b0;
      errsig_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        LD_AH: if (bus.locksig) begin
          a_d     = {1'b0, bus.inbus};
          state_d = LD_AL;
        end
        LD_AL: if (bus.locksig) begin
          q_d     = bus.inbus;
          state_d = LD_B;
        end
        LD_B: if (bus.locksig) begin
          b_d     = bus.inbus;
          state_d = CHECK;
        end
        CHECK: begin
          // Quotient fits in WIDTH bits only when the high half is below the divisor.
          if ((b_q == '0) || (a_q[WIDTH-1:0] >= b_q)) begin
            err_d    = 1'b1;
            outbus_d = '0;
            state_d  = DONE;
          end else begin
            cnt_d   = CW'(WIDTH);
            state_d = DIV;
          end
        end
        DIV: begin
          a_d   = a_new_c;
          q_d   = {q_q[WIDTH-2:0], ~a_new_c[WIDTH]};
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = CORR;
        end
        CORR: begin
          if (a_q[WIDTH]) a_d = a_q + {1'b0, b_q};
          state_d = OUT_Q;
        end
        OUT_Q: begin
          outbus_d = q_q;
`ifdef BOOTH_DIV_REM_OUT_EN
          state_d  = OUT_R;
`else
          endsig_d = 1'b1;
          state_d  = DONE;
`endif
        end
`ifdef BOOTH_DIV_REM_OUT_EN
        OUT_R: begin
          outbus_d = a_q[WIDTH-1:0];
          endsig_d = 1'b1;
          state_d  = DONE;
        end
`endif
        DONE: begin
          endsig_d = 1'b1;
          errsig_d = err_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      q_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      outbus_q <= '0;
      endsig_q <= 1'b0;
      errsig_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      q_q      <= q_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      outbus_q <= outbus_d;
      endsig_q <= endsig_d;
      errsig_q <= errsig_d;
    end
  end

  assign bus.outbus = outbus_q;
  assign bus.endsig = endsig_q;
  assign bus.errsig = errsig_q;

endmodule

// File: tb/tb_booth_divider.sv
// tb_booth_divider: directed and randomized checks of booth_divider against a plain-arithmetic model.
module tb_booth_divider;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  booth_divider_if #(.WIDTH(8)) bus_if ();

  booth_divider #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse beginsig, then load AH, AL, (stall cycles with junk on inbus), B. Returns after edge 3+stall.
  task automatic start_op(input logic [7:0] ah, input logic [7:0] al, input logic [7:0] b,
                          input int stall);
    @(negedge clk);
    bus_if.beginsig = 1'b1;
    bus_if.locksig  = 1'($urandom_range(0, 1));
    bus_if.inbus    = 8'($urandom);
    @(negedge clk);
    chk("begin_endsig", 32'(bus_if.endsig), 32'd0);
    chk("begin_errsig", 32'(bus_if.errsig), 32'd0);
    chk("begin_outbus", 32'(bus_if.outbus), 32'd0);
    bus_if.beginsig = 1'b0;
    bus_if.locksig  = 1'b1;
    bus_if.inbus    = ah;
    @(negedge clk);
    bus_if.inbus    = al;
    @(negedge clk);
    for (int i = 0; i < stall; i++) begin
      bus_if.locksig = 1'b0;
      bus_if.inbus   = 8'($urandom);
      @(negedge clk);
    end
    bus_if.locksig  = 1'b1;
    bus_if.inbus    = b;
    @(negedge clk);
    bus_if.locksig  = 1'($urandom_range(0, 1));
    bus_if.inbus    = 8'($urandom);
  endtask

  // Wait for endsig and compare result, flags and latency against arithmetic division.
  task automatic finish_op(input logic [7:0] ah, input logic [7:0] al, input logic [7:0] b,
                           input int stall, input string tag);
    int unsigned dividend;
    int unsigned exp_q;
    int unsigned exp_r;
    bit          exp_err;
    int          exp_edge;
    int          n;
    bit          done;
    logic [7:0]  prev;
    dividend = {16'd0, ah, al};
    exp_err  = (b == 8'd0) || (dividend / 32'(b) > 32'd255);
    exp_q    = exp_err ? 0 : dividend / 32'(b);
    exp_r    = exp_err ? 0 : dividend % 32'(b);
`ifdef BOOTH_DIV_REM_OUT_EN
    exp_edge = exp_err ? 5 + stall : 15 + stall;
`else
    exp_edge = exp_err ? 5 + stall : 14 + stall;
`endif
    n    = 0;
    done = 1'b0;
    prev = bus_if.outbus;
    while (!done && n < 40) begin
      prev = bus_if.outbus;
      @(negedge clk);
      n++;
      if (bus_if.endsig === 1'b1) done = 1'b1;
    end
    chk({tag, "_timeout"}, 32'(done), 32'd1);
    chk({tag, "_latency"}, 32'(3 + stall + n), 32'(exp_edge));
    chk({tag, "_errsig"}, 32'(bus_if.errsig), 32'(exp_err));
`ifdef BOOTH_DIV_REM_OUT_EN
    chk({tag, "_rem"}, 32'(bus_if.outbus), exp_r);
    if (!exp_err) chk({tag, "_quot"}, 32'(prev), exp_q);
`else
    chk({tag, "_quot"}, 32'(bus_if.outbus), exp_q);
`endif
    @(negedge clk);
    chk({tag, "_hold_end"}, 32'(bus_if.endsig), 32'd1);
`ifdef BOOTH_DIV_REM_OUT_EN
    chk({tag, "_hold_out"}, 32'(bus_if.outbus), exp_r);
`else
    chk({tag, "_hold_out"}, 32'(bus_if.outbus), exp_q);
`endif
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rl;
    logic [7:0] rb;
    int         rs;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus_if.beginsig = 1'b0;
    bus_if.locksig  = 1'b0;
    bus_if.inbus    = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_outbus", 32'(bus_if.outbus), 32'd0);
    chk("rst_endsig", 32'(bus_if.endsig), 32'd0);
    chk("rst_errsig", 32'(bus_if.errsig), 32'd0);
    rst_n = 1'b1;

    // Idle ignores lock/inbus.
    for (int i = 0; i < 3; i++) begin
      bus_if.locksig = 1'b1;
      bus_if.inbus   = 8'($urandom);
      @(negedge clk);
      chk("idle_endsig", 32'(bus_if.endsig), 32'd0);
      chk("idle_outbus", 32'(bus_if.outbus), 32'd0);
    end

    // 1000 / 7 with exact edge timing.
    start_op(8'h03, 8'hE8, 8'h07, 0);
    repeat (2) @(negedge clk);
    chk("t1000_e5_endsig", 32'(bus_if.endsig), 32'd0);
    chk("t1000_e5_errsig", 32'(bus_if.errsig), 32'd0);
    repeat (9) @(negedge clk);
    chk("t1000_e14_quot", 32'(bus_if.outbus), 32'h8E);
`ifdef BOOTH_DIV_REM_OUT_EN
    chk("t1000_e14_endsig", 32'(bus_if.endsig), 32'd0);
    @(negedge clk);
    chk("t1000_e15_rem", 32'(bus_if.outbus), 32'h06);
    chk("t1000_e15_endsig", 32'(bus_if.endsig), 32'd1);
    chk("t1000_e15_errsig", 32'(bus_if.errsig), 32'd0);
`else
    chk("t1000_e14_endsig", 32'(bus_if.endsig), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t1000_hold_quot", 32'(bus_if.outbus), 32'h8E);
      chk("t1000_hold_endsig", 32'(bus_if.endsig), 32'd1);
    end
`endif

    // Directed boundary cases.
    start_op(8'h00, 8'hFF, 8'h01, 0);  finish_op(8'h00, 8'hFF, 8'h01, 0, "ff_div_1");
    start_op(8'h00, 8'hFE, 8'hFF, 0);  finish_op(8'h00, 8'hFE, 8'hFF, 0, "fe_div_ff");
    start_op(8'h12, 8'h34, 8'h00, 0);  finish_op(8'h12, 8'h34, 8'h00, 0, "div_zero");
    start_op(8'h05, 8'h00, 8'h05, 0);  finish_op(8'h05, 8'h00, 8'h05, 0, "overflow");
    start_op(8'h03, 8'hE8, 8'h07, 3);  finish_op(8'h03, 8'hE8, 8'h07, 3, "stall3");
    start_op(8'hFE, 8'hFF, 8'hFF, 0);  finish_op(8'hFE, 8'hFF, 8'hFF, 0, "max_quot");

    // Abort mid-DIV with a new operation.
    start_op(8'h03, 8'hE8, 8'h07, 0);
    repeat (4) @(negedge clk);
    start_op(8'h00, 8'h64, 8'h0A, 0);  finish_op(8'h00, 8'h64, 8'h0A, 0, "abort");

    // Asynchronous reset while outputs are non-zero (error done state).
    start_op(8'h20, 8'h00, 8'h00, 0);  finish_op(8'h20, 8'h00, 8'h00, 0, "pre_rst");
    #2 rst_n = 1'b0;
    #1;
    chk("arst_endsig", 32'(bus_if.endsig), 32'd0);
    chk("arst_errsig", 32'(bus_if.errsig), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-DIV, then the FSM must sit idle.
    start_op(8'h03, 8'hE8, 8'h07, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("div_rst_outbus", 32'(bus_if.outbus), 32'd0);
    chk("div_rst_endsig", 32'(bus_if.endsig), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus_if.locksig = 1'b1;
      bus_if.inbus   = 8'($urandom);
      @(negedge clk);
      if (i % 4 == 3) begin
        chk("post_rst_endsig", 32'(bus_if.endsig), 32'd0);
        chk("post_rst_outbus", 32'(bus_if.outbus), 32'd0);
      end
    end

    // Randomized operations.
    for (int k = 0; k < 24; k++) begin
      rb = 8'($urandom_range(0, 255));
      if (k % 6 == 5 || rb == 8'd0) ra = 8'($urandom);
      else ra = 8'($urandom_range(0, 32'(rb) - 1));
      rl = 8'($urandom);
      rs = $urandom_range(0, 2);
      start_op(ra, rl, rb, rs);
      finish_op(ra, rl, rb, rs, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/booth_divider.md
# booth_divider

Sequential unsigned divider sharing the byte-wide `inbus`/`outbus` begin/lock/end protocol of the Booth multiplier. It is the inverse arithmetic unit on the same datapath: operands are loaded over `inbus`, the divider runs a non-restoring loop, and results are returned over `outbus`. It sits beside the multiplier behind the same operand sequencer.

## Interface
- `WIDTH`, 8: divisor, quotient and remainder width in bits. The dividend is 2*`WIDTH` bits.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `beginsig` in 1: start/restart request, sampled on `clk`.
- `locksig` in 1: operand-valid qualifier for `inbus` during load states.
- `inbus` in `WIDTH`: operand byte.
- `outbus` out `WIDTH`: result byte (registered).
- `endsig` out 1: operation complete (registered, level).
- `errsig` out 1: divide-by-zero or quotient overflow (registered, level).

## Operation
- States: IDLE, LD_AH, LD_AL, LD_B, CHECK, DIV, CORR, OUT_Q, OUT_R, DONE.
- Reset (`rst_n`=0): state=IDLE, all registers 0; `outbus`=0, `endsig`=0, `errsig`=0.
- `beginsig`=1 in any state: next state is LD_AH; clear A, Q, B and the counter; `endsig`=0, `errsig`=0, `outbus`=0. `beginsig` has priority over every other transition, so it aborts an operation in flight.
- Load states:
  - LD_AH captures `inbus` into the dividend high half (A).
  - LD_AL captures `inbus` into the dividend low half (Q).
  - LD_B captures `inbus` into the divisor (B).
  - Each load captures and advances only on an edge where `locksig`=1 and `beginsig`=0. Otherwise the state holds and no capture occurs.
- CHECK (1 cycle):
  - If B==0 or A>=B (unsigned), go to DONE with `errsig`=1, `endsig`=1, `outbus`=0.
  - Otherwise load counter=`WIDTH` and go to DIV.
- DIV (`WIDTH` cycles, non-restoring):
  - Shift {A,Q} left by 1.
  - If A was non-negative, A=A−B; else A=A+B.
  - Q[0] = ~A_new sign bit.
  - A is `WIDTH`+1 bits wide to hold the sign.
  - Decrement the counter; at 0, go to CORR.
- CORR (1 cycle): if A is negative, A=A+B. The remainder is A[`WIDTH`-1:0].
- OUT_Q: `outbus`=Q (quotient).
- OUT_R: `outbus`=remainder.
- DONE: `endsig`=1 and `outbus` holds the last value until the next `beginsig`. `locksig` and `inbus` are ignored in DONE and IDLE.

## Timing
- Edge 0 samples `beginsig`. With `locksig` held at 1, edges 1–3 load AH, AL and B.
- Edge 4 is CHECK. Edges 5..4+`WIDTH` are DIV. Edge 5+`WIDTH` is CORR.
- `outbus`=quotient is visible after edge 6+`WIDTH`.
- `outbus`=remainder is visible after edge 7+`WIDTH`; `endsig` rises together with it. For `WIDTH`=8 this is edge 15.
- Error path: `endsig`=`errsig`=1 visible after edge 5.
- Each cycle with `locksig`=0 during a load state adds exactly 1 cycle of latency.
- Reset asserted mid-operation returns all outputs to 0 immediately, independent of `clk`.

## Configuration
- `BOOTH_DIV_REM_OUT_EN` defined: the OUT_R state exists, and remainder follows quotient as described above.
- Not defined: OUT_R is removed. `endsig` rises one cycle earlier, together with quotient on `outbus`, and DONE holds the quotient.
- The error path and all other behaviour are identical in both builds.

## Test plan
- Dividend 0x03E8 (1000), divisor 0x07, `locksig` held high → `outbus`=0x8E (142) after edge 14, then 0x06 with `endsig`=1 after edge 15, `errsig`=0.
- Dividend 0x00FF, divisor 0x01 → quotient 0xFF, remainder 0x00. Dividend 0x00FE, divisor 0xFF → quotient 0x00, remainder 0xFE.
- Divisor 0x00 → `errsig`=1 and `endsig`=1 after edge 5, `outbus`=0x00. Dividend 0x0500, divisor 0x05 (overflow) → same response.
- `locksig` low for 3 cycles between the AL and B loads of the 1000/7 case → same results, `endsig` 3 cycles later; no spurious capture occurs while `locksig` is low.
- `beginsig` pulsed mid-DIV, then new operands 0x0064/0x0A loaded → `endsig` drops immediately, result is quotient 0x0A, remainder 0x00. `rst_n` pulsed low mid-DIV → all outputs 0 asynchronously, FSM in IDLE.
- Build without `BOOTH_DIV_REM_OUT_EN`, 1000/7 → `endsig`=1 with `outbus`=0x8E after edge 14, held stable for 10 further cycles.
